// File: rtl/menu_pkg.sv
// Shared encodings for the menu sequencer: FSM states, conditioner states,
// app ids and the bit positions of the three button events.
package menu_pkg;

  typedef enum logic [1:0] {
    S_MENU   = 2'd0,
    S_ENTER  = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  typedef enum logic {
    C_IDLE  = 1'b0,
    C_ARMED = 1'b1
  } cond_e;

  localparam int APP_MENU  = 0;
  localparam int APP_FIRST = 1;
  localparam int APP_GIF   = 7;

  localparam int EV_R = 0;
  localparam int EV_L = 1;
  localparam int EV_C = 2;
  localparam int NUM_BTN = 3;

endpackage

// File: rtl/btn_release_detect.sv
// Turns a button into a single-cycle release event once it has stayed low
// for RELEASE_CYCLES consecutive cycles after a press.
module btn_release_detect
  import menu_pkg::*;
#(
  parameter int RELEASE_CYCLES = 6_250_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic ev
);

  localparam int CW = $clog2(RELEASE_CYCLES + 1);

  cond_e         st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q  <= C_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // ev fires in the cycle whose low sample completes the window
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    ev    = 1'b0;
    case (st_q)
      C_IDLE: begin
        if (btn) begin
          st_d  = C_ARMED;
          cnt_d = '0;
        end
      end
      C_ARMED: begin
        if (btn) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(RELEASE_CYCLES - 1)) begin
          ev    = 1'b1;
          st_d  = C_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        st_d  = C_IDLE;
        cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/menu_sequencer.sv
// App sequencer: three release detectors feed a menu FSM that moves the
// cursor, enters an app with a timed app_rst pulse, and returns on back.
module menu_sequencer
  import menu_pkg::*;
#(
  parameter int RELEASE_CYCLES   = 6_250_000,
  parameter int NUM_APPS         = 8,
  parameter int STATE_W          = 3,
  parameter int ENTRY_RST_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                btnC,
  input  logic                btnL,
  input  logic                btnR,
  output logic [STATE_W-1:0]  machine_state,
  output logic [STATE_W-1:0]  menu_cursor,
  output logic [NUM_APPS-1:0] app_en,
  output logic                app_rst,
  output logic                busy
);

  localparam int RW = $clog2(ENTRY_RST_CYCLES + 1);
  localparam logic [STATE_W-1:0] CUR_MIN = STATE_W'(APP_FIRST);
  localparam logic [STATE_W-1:0] CUR_MAX = STATE_W'(NUM_APPS - 1);

  logic [NUM_BTN-1:0] ev;

  btn_release_detect #(.RELEASE_CYCLES(RELEASE_CYCLES)) u_det [NUM_BTN-1:0] (
    .clock (clock),
    .reset (reset),
    .btn   ({btnC, btnL, btnR}),
    .ev    (ev)
  );

  state_e             st_q, st_d;
  logic [STATE_W-1:0] ms_q, ms_d;
  logic [STATE_W-1:0] cur_q, cur_d;
  logic [RW-1:0]      rcnt_q, rcnt_d;
  logic               rst_q, rst_d;
  logic               busy_q, busy_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      st_q   <= S_MENU;
      ms_q   <= STATE_W'(APP_MENU);
      cur_q  <= CUR_MIN;
      rcnt_q <= '0;
      rst_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      ms_q   <= ms_d;
      cur_q  <= cur_d;
      rcnt_q <= rcnt_d;
      rst_q  <= rst_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    ms_d   = ms_q;
    cur_d  = cur_q;
    rcnt_d = rcnt_q;
    rst_d  = rst_q;
    busy_d = busy_q;
    case (st_q)
      S_MENU: begin
        if (ev[EV_C]) begin
          ms_d   = cur_q;
          rst_d  = 1'b1;
          busy_d = 1'b1;
          rcnt_d = '0;
          st_d   = S_ENTER;
        end else if (ev[EV_L]) begin
          cur_d = (cur_q == CUR_MIN) ? CUR_MAX : cur_q - STATE_W'(1);
        end else if (ev[EV_R]) begin
          cur_d = (cur_q == CUR_MAX) ? CUR_MIN : cur_q + STATE_W'(1);
        end
      end
      // rcnt counts app_rst-high cycles; the first one is rcnt==0
      S_ENTER: begin
        if (rcnt_q == RW'(ENTRY_RST_CYCLES - 1)) begin
          rst_d  = 1'b0;
          busy_d = 1'b0;
          rcnt_d = '0;
          st_d   = S_ACTIVE;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      S_ACTIVE: begin
        if (ev[EV_L]) begin
          ms_d = STATE_W'(APP_MENU);
          st_d = S_MENU;
        end
      end
      default: begin
        st_d   = S_MENU;
        ms_d   = STATE_W'(APP_MENU);
        rst_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign machine_state = ms_q;
  assign menu_cursor   = cur_q;
  assign app_en        = NUM_APPS'(1) << ms_q;
  assign app_rst       = rst_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_menu_sequencer.sv
// Scoreboarded bench for menu_sequencer with a short release window.
module tb_menu_sequencer;

  logic       clock = 1'b0;
  logic       reset, btnC, btnL, btnR;
  logic [2:0] machine_state, menu_cursor;
  logic [7:0] app_en;
  logic       app_rst, busy;

  menu_sequencer #(
    .RELEASE_CYCLES(4), .NUM_APPS(8), .STATE_W(3), .ENTRY_RST_CYCLES(2)
  ) dut (
    .clock(clock), .reset(reset), .btnC(btnC), .btnL(btnL), .btnR(btnR),
    .machine_state(machine_state), .menu_cursor(menu_cursor),
    .app_en(app_en), .app_rst(app_rst), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string tag;
    int    ms, cur, rst, bsy;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // drive at the falling edge, return at the next falling edge
  task automatic step(input logic c, input logic l, input logic r);
    btnC = c; btnL = l; btnR = r;
    @(negedge clock);
  endtask

  task automatic rel(input logic c, input logic l, input logic r);
    step(c, l, r);
    repeat (4) step(0, 0, 0);
  endtask

  task automatic push(input string tag, input int ms, input int cur,
                      input int rst, input int bsy);
    exp_t e;
    e.tag = tag; e.ms = ms; e.cur = cur; e.rst = rst; e.bsy = bsy;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sbq.pop_front();
      chk({e.tag, ".ms"},   int'(machine_state), e.ms);
      chk({e.tag, ".cur"},  int'(menu_cursor),   e.cur);
      chk({e.tag, ".en"},   int'(app_en),        1 << e.ms);
      chk({e.tag, ".rst"},  int'(app_rst),       e.rst);
      chk({e.tag, ".busy"}, int'(busy),          e.bsy);
    end
  endtask

  initial begin
    reset = 1'b1; btnC = 1'b0; btnL = 1'b0; btnR = 1'b0;
    @(negedge clock);
    push("reset", 0, 1, 0, 0);
    step(0, 0, 0);
    pop_cmp();
    reset = 1'b0;

    // 1: window of 4 low cycles
    push("r_early", 0, 1, 0, 0);
    push("r_fire", 0, 2, 0, 0);
    step(0, 0, 1); repeat (3) step(0, 0, 0);
    pop_cmp();
    step(0, 0, 0);
    pop_cmp();

    // 2: wrap both ways
    push("l_2to1", 0, 1, 0, 0); rel(0, 1, 0); pop_cmp();
    push("l_wrap", 0, 7, 0, 0); rel(0, 1, 0); pop_cmp();
    push("r_wrap", 0, 1, 0, 0); rel(0, 0, 1); pop_cmp();
    push("l_to7",  0, 7, 0, 0); rel(0, 1, 0); pop_cmp();

    // 3: enter app 7, reset pulse of 2 cycles
    push("enter",   7, 7, 1, 1);
    push("enter2",  7, 7, 1, 1);
    push("active",  7, 7, 0, 0);
    rel(1, 0, 0); pop_cmp();
    step(0, 0, 0); pop_cmp();
    step(0, 0, 0); pop_cmp();
    push("act_r",   7, 7, 0, 0); rel(0, 0, 1); pop_cmp();
    push("act_c",   7, 7, 0, 0); rel(1, 0, 0); pop_cmp();
    push("back",    0, 7, 0, 0); rel(0, 1, 0); pop_cmp();

    // 4: C and L together, C wins
    push("cl_same", 7, 7, 1, 1);
    push("cl_act",  7, 7, 0, 0);
    push("cl_back", 0, 7, 0, 0);
    rel(1, 1, 0); pop_cmp();
    repeat (2) step(0, 0, 0); pop_cmp();
    rel(0, 1, 0); pop_cmp();

    // 5: bounce restarts the window; a held button never fires
    push("bounce",   0, 7, 0, 0);
    push("bnc_fire", 0, 1, 0, 0);
    step(0, 0, 1); repeat (3) step(0, 0, 0);
    step(0, 0, 1); repeat (3) step(0, 0, 0);
    pop_cmp();
    step(0, 0, 0); pop_cmp();
    push("held",      0, 1, 0, 0);
    push("held_rel",  0, 2, 0, 0);
    repeat (20) step(0, 0, 1);
    pop_cmp();
    repeat (4) step(0, 0, 0);
    pop_cmp();

    // 6: reset during S_ENTER with a half-counted btnL
    push("pre_rst",  2, 2, 1, 1);
    push("in_rst",   0, 1, 0, 0);
    push("post_rst", 0, 1, 0, 0);
    step(1, 0, 0); step(0, 1, 0); repeat (3) step(0, 0, 0);
    pop_cmp();
    reset = 1'b1;
    step(0, 0, 0);
    pop_cmp();
    reset = 1'b0;
    repeat (8) step(0, 0, 0);
    pop_cmp();

    chk("sb_left", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
